dpram_arbiter: RTL and testbench

Controller that shares the dual-port RAM (dpram) between NUM_REQ requesters. Each cycle it picks up to two requests round-robin and issues one on RAM port A and one on RAM port B. It suppresses same-address hazards between the two ports and routes read data back to the issuing requester. After reset it optionally zero-fills the RAM through port A before serving requests.

---
 rtl/dpram_ctrl_pkg.sv | 13 +
 rtl/rr_pick2.sv | 32 +++
 rtl/dpram_arbiter.sv | 122 ++++++++++++
 tb/tb_dpram_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_ctrl_pkg.sv
// dpram_ctrl_pkg: shared types, defaults and helpers for the dual-port RAM arbiter
package dpram_ctrl_pkg;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic {ST_CLEAR, ST_RUN} ctrl_state_t;
    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1) % n;
    endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: finds the first two valid requesters scanning cyclically from ptr_i
module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    g0_o,
    output logic [ID_W-1:0]    g1_o,
    output logic               found0_o,
    output logic               found1_o
);
    logic [ID_W-1:0] idx;

    always_comb begin
        g0_o = '0;
        g1_o = '0;
        found0_o = 1'b0;
        found1_o = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (valid_i[idx] && !found0_o) begin
                g0_o = idx;
                found0_o = 1'b1;
            end else if (valid_i[idx] && !found1_o) begin
                g1_o = idx;
                found1_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: shares a dual-port RAM between requesters, two grants per cycle,
// with same-address hazard suppression and an optional post-reset zero fill.
module dpram_arbiter
    import dpram_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int DEPTH          = 2 ** ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic                      ram_valid_a,
    output logic                      ram_valid_b,
    input  logic                      ram_ready_a,
    input  logic                      ram_ready_b,
    output logic                      ram_we_a,
    output logic                      ram_we_b,
    output logic [ADDR_W-1:0]         ram_addr_a,
    output logic [ADDR_W-1:0]         ram_addr_b,
    output logic [DATA_W-1:0]         ram_data_a,
    output logic [DATA_W-1:0]         ram_data_b,
    input  logic [DATA_W-1:0]         ram_q_a,
    input  logic [DATA_W-1:0]         ram_q_b,
    output logic                      init_done,
    output logic [CNT_W-1:0]          collision_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);

    ctrl_state_t       state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, g0, g1, id_a_q, id_b_q;
    logic              found0, found1, init_done_q, rd_a_q, rd_b_q;
    logic [CNT_W-1:0]  collision_q;
    logic              clearing, hazard, issue_a, issue_b, acc_a, acc_b;
    logic [ADDR_W-1:0] addr0, addr1;

    rr_pick2 #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .g0_o    (g0),
        .g1_o    (g1),
        .found0_o(found0),
        .found1_o(found1)
    );

    assign clearing = state_q == ST_CLEAR;
    assign addr0    = req_addr[int'(g0)*ADDR_W +: ADDR_W];
    assign addr1    = req_addr[int'(g1)*ADDR_W +: ADDR_W];
    // Port B yields on any same-address pair involving a write; it becomes G0 next cycle.
    assign hazard   = !clearing && found1 && addr0 == addr1 && (req_we[g0] || req_we[g1]);
    assign issue_a  = !clearing && found0;
    assign issue_b  = !clearing && found1 && !hazard;
    assign acc_a    = issue_a && ram_ready_a;
    assign acc_b    = issue_b && ram_ready_b;

    assign ram_valid_a = clearing || issue_a;
    assign ram_we_a    = clearing || (issue_a && req_we[g0]);
    assign ram_addr_a  = clearing ? clr_cnt_q : (issue_a ? addr0 : '0);
    assign ram_data_a  = issue_a ? req_wdata[int'(g0)*DATA_W +: DATA_W] : '0;
    assign ram_valid_b = issue_b;
    assign ram_we_b    = issue_b && req_we[g1];
    assign ram_addr_b  = issue_b ? addr1 : '0;
    assign ram_data_b  = issue_b ? req_wdata[int'(g1)*DATA_W +: DATA_W] : '0;

    assign rr_ptr_d = acc_b ? ID_W'(wrap_inc(32'(g1), NUM_REQ)) :
                      acc_a ? ID_W'(wrap_inc(32'(g0), NUM_REQ)) : rr_ptr_q;

    assign init_done     = init_done_q;
    assign collision_cnt = collision_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        logic hit_a, hit_b;
        assign req_ready[i] = (acc_a && g0 == ID_W'(i)) || (acc_b && g1 == ID_W'(i));
        assign hit_a = rd_a_q && id_a_q == ID_W'(i);
        assign hit_b = rd_b_q && id_b_q == ID_W'(i);
        assign rsp_valid[i] = hit_a || hit_b;
        assign rsp_data[i*DATA_W +: DATA_W] = hit_a ? ram_q_a : (hit_b ? ram_q_b : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
            if (CLEAR_ON_RESET) begin
                state_q     <= ST_CLEAR;
                init_done_q <= 1'b0;
            end
            clr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            rd_a_q      <= 1'b0;
            rd_b_q      <= 1'b0;
            id_a_q      <= '0;
            id_b_q      <= '0;
            collision_q <= '0;
        end else begin
            if (clearing && ram_ready_a) begin
                clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
                end
            end
            rr_ptr_q <= rr_ptr_d;
            rd_a_q   <= acc_a && !req_we[g0];
            rd_b_q   <= acc_b && !req_we[g1];
            id_a_q   <= g0;
            id_b_q   <= g1;
            if (hazard && !(&collision_q))
                collision_q <= collision_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: directed and random stimulus checked against a behavioural
// arbitration/memory model; the RAM itself is modelled separately from the reference.
module tb_dpram_arbiter;
    localparam int N = 4, AW = 8, DW = 8, CW = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, rsp_data;
    logic ram_valid_a, ram_valid_b, ram_ready_a, ram_ready_b, ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic init_done;
    logic [CW-1:0] collision_cnt;

    logic [DW-1:0] ram [256];
    logic [DW-1:0] ref_mem [256];
    logic [N-1:0]  pend, exp_rv;
    logic          t_we [N];
    logic [AW-1:0] t_addr [N];
    logic [DW-1:0] t_wd [N];
    logic [DW-1:0] exp_rd [N];
    int m_rr, m_coll, n_chk, n_pass;

    dpram_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_valid_a(ram_valid_a), .ram_valid_b(ram_valid_b),
        .ram_ready_a(ram_ready_a), .ram_ready_b(ram_ready_b),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
        .init_done(init_done), .collision_cnt(collision_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_valid_a && ram_ready_a) begin
            if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
            else ram_q_a <= ram[ram_addr_a];
        end
        if (ram_valid_b && ram_ready_b) begin
            if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
            else ram_q_b <= ram[ram_addr_b];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic set_req(input int id, input logic we, input int addr, input int wd);
        pend[id]   = 1'b1;
        t_we[id]   = we;
        t_addr[id] = AW'(addr);
        t_wd[id]   = DW'(wd);
    endtask

    // One RUN cycle: entered at a negedge, drives requests, checks, advances the model.
    task automatic cycle();
        int g0, g1, id;
        logic haz, ib, aa, ab;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) begin
            req_we[i] = t_we[i];
            req_addr[i*AW +: AW] = t_addr[i];
            req_wdata[i*DW +: DW] = t_wd[i];
        end
        req_valid = pend;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        for (int i = 0; i < N; i++)
            if (exp_rv[i]) chk("rsp_data", 32'(rsp_data[i*DW +: DW]), 32'(exp_rd[i]));
        chk("collision_cnt", 32'(collision_cnt), 32'(m_coll));
        chk("init_done", 32'(init_done), 32'd1);
        g0 = -1;
        g1 = -1;
        for (int k = 0; k < N; k++) begin
            id = (m_rr + k) % N;
            if (pend[id] && g0 < 0) g0 = id;
            else if (pend[id] && g1 < 0) g1 = id;
        end
        haz = g1 >= 0 && t_addr[g0] == t_addr[g1] && (t_we[g0] || t_we[g1]);
        ib  = g1 >= 0 && !haz;
        aa  = g0 >= 0 && ram_ready_a;
        ab  = ib && ram_ready_b;
        er  = '0;
        if (aa) er[g0] = 1'b1;
        if (ab) er[g1] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("ram_valid_a", 32'(ram_valid_a), 32'(g0 >= 0));
        chk("ram_valid_b", 32'(ram_valid_b), 32'(ib));
        if (g0 >= 0) chk("ram_addr_a", 32'(ram_addr_a), 32'(t_addr[g0]));
        if (ib) chk("ram_addr_b", 32'(ram_addr_b), 32'(t_addr[g1]));
        exp_rv = '0;
        if (aa && !t_we[g0]) begin exp_rv[g0] = 1'b1; exp_rd[g0] = ref_mem[t_addr[g0]]; end
        if (ab && !t_we[g1]) begin exp_rv[g1] = 1'b1; exp_rd[g1] = ref_mem[t_addr[g1]]; end
        if (aa && t_we[g0]) ref_mem[t_addr[g0]] = t_wd[g0];
        if (ab && t_we[g1]) ref_mem[t_addr[g1]] = t_wd[g1];
        if (haz && m_coll < 65535) m_coll++;
        if (ab) m_rr = (g1 + 1) % N;
        else if (aa) m_rr = (g0 + 1) % N;
        pend = pend & ~er;
        @(negedge clk);
    endtask

    // Entered at the negedge right after reset release; walks the zero fill.
    task automatic run_clear();
        ram_ready_a = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 256; c++) begin
            ram_ready_b = 1'($urandom_range(0, 1));
            #1;
            chk("clr_addr", 32'(ram_addr_a), 32'(c));
            chk("clr_wr", 32'({ram_valid_a, ram_we_a, ram_data_a}), {22'd0, 2'b11, 8'd0});
            chk("clr_idle", 32'({req_ready, ram_valid_b, rsp_valid, init_done}), 32'd0);
            @(negedge clk);
        end
        chk("clr_done", 32'(init_done), 32'd1);
        m_rr = 0;
        m_coll = 0;
        exp_rv = '0;
        pend = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = '0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        pend = '0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        ram_ready_a = 1'b1;
        ram_ready_b = 1'b1;
        for (int i = 0; i < N; i++) begin t_we[i] = 1'b0; t_addr[i] = '0; t_wd[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_coll", 32'(collision_cnt), 32'd0);
        rst = 1'b0;
        run_clear();

        set_req(0, 1'b0, 8'h7F, 0);
        cycle();
        chk("rd7f", 32'({rsp_valid, rsp_data[7:0]}), {24'd0, 4'b0001, 8'h00});

        set_req(2, 1'b1, 8'h10, 8'hA5);
        cycle();
        set_req(2, 1'b0, 8'h10, 0);
        cycle();
        chk("wr_rd_valid", 32'(rsp_valid), 32'h4);
        chk("wr_rd_data", 32'(rsp_data[23:16]), 32'hA5);

        set_req(3, 1'b0, 8'h00, 0);
        cycle();
        set_req(0, 1'b1, 8'h20, 8'h55);
        set_req(1, 1'b0, 8'h20, 0);
        cycle();
        chk("haz_coll", 32'(collision_cnt), 32'd1);
        cycle();
        chk("haz_valid", 32'(rsp_valid), 32'h2);
        chk("haz_data", 32'(rsp_data[15:8]), 32'h55);

        ram_ready_b = 1'b0;
        set_req(0, 1'b0, 8'h10, 0);
        set_req(1, 1'b0, 8'h20, 0);
        cycle();
        chk("stall_rsp0", 32'({rsp_valid, rsp_data[7:0]}), {24'd0, 4'b0001, 8'hA5});
        cycle();
        chk("stall_rsp1", 32'({rsp_valid, rsp_data[15:8]}), {24'd0, 4'b0010, 8'h55});
        ram_ready_b = 1'b1;

        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 0);
            cycle();
            chk("fair_pair", 32'($countones(rsp_valid)), 32'd2);
        end

        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            ram_ready_a = $urandom_range(0, 3) != 0;
            ram_ready_b = $urandom_range(0, 3) != 0;
            cycle();
        end
        pend = '0;
        ram_ready_a = 1'b1;
        ram_ready_b = 1'b1;
        cycle();

        req_valid = 4'b0001;
        req_we = '0;
        req_addr = '0;
        req_addr[7:0] = 8'h05;
        rst = 1'b1;
        #1;
        chk("rst_accept", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_rst_init", 32'(init_done), 32'd0);
        run_clear();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            ram_ready_a = $urandom_range(0, 3) != 0;
            ram_ready_b = $urandom_range(0, 3) != 0;
            cycle();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
